// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares the single-port data memory between the core load/store unit
//   (port C) and the DMA/debug loader (port D). Round-robin arbitration
//   between the two request channels, with one transaction in flight at a time.
//   The memory's we/A/wd are driven from registers. A misaligned address is
//   answered with an error response and never reaches the memory.
//
//   Sequence: IDLE (grant) -> ACCESS (1 cycle, memory strobe) -> RESP (hold
//   until the owner accepts). A misaligned request skips ACCESS.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   c_req_*  / d_req_*    request channel (valid/ready, we, addr, wdata)
//   c_rsp_*  / d_rsp_*    response channel (valid/ready, rdata, err)
//   mem_we/mem_addr/mem_wd  registered drive to the data memory
//   mem_rd                combinational read data from the data memory
//   busy                  high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          c_req_valid,
    output logic          c_req_ready,
    input  logic          c_req_we,
    input  logic [AW-1:0] c_req_addr,
    input  logic [DW-1:0] c_req_wdata,
    output logic          c_rsp_valid,
    input  logic          c_rsp_ready,
    output logic [DW-1:0] c_rsp_rdata,
    output logic          c_rsp_err,

    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_we,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_rsp_valid,
    input  logic          d_rsp_ready,
    output logic [DW-1:0] d_rsp_rdata,
    output logic          d_rsp_err,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,

    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          sel_dma;
    logic          grant;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          owner_rsp_ready;

    // Arbitration: a lone requester wins outright; on a tie the port that
    // was not granted last time wins.
    always_comb begin
        if (c_req_valid && d_req_valid) begin
            sel_dma = (last_grant_q == PORT_C);
        end else begin
            sel_dma = d_req_valid;
        end
    end

    // Ready is gated by rst_n so that both readies drop the moment reset is
    // asserted, even while a requester keeps valid high.
    assign c_req_ready = rst_n && (state_q == ST_IDLE) && c_req_valid && !sel_dma;
    assign d_req_ready = rst_n && (state_q == ST_IDLE) && d_req_valid &&  sel_dma;
    assign grant       = c_req_ready || d_req_ready;

    assign req_we    = sel_dma ? d_req_we    : c_req_we;
    assign req_addr  = sel_dma ? d_req_addr  : c_req_addr;
    assign req_wdata = sel_dma ? d_req_wdata : c_req_wdata;

    assign owner_rsp_ready = (owner_q == PORT_D) ? d_rsp_ready : c_rsp_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        err_d        = err_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d      = sel_dma;
                    last_grant_d = sel_dma;
                    we_d         = req_we;
                    if (req_addr[1:0] == 2'b00) begin
                        mem_addr_d = req_addr;
                        mem_wd_d   = req_wdata;
                        mem_we_d   = req_we;
                        state_d    = ST_ACCESS;
                    end else begin
                        // Misaligned: memory untouched, answer straight away.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // The write commits at the edge closing this cycle; a load
                // samples the combinational read data at the same edge.
                rdata_d  = we_q ? '0 : mem_rd;
                mem_we_d = 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (owner_rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_D;
            owner_q      <= PORT_C;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            err_q        <= err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            rdata_q      <= rdata_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wd      = mem_wd_q;

    assign c_rsp_valid = (state_q == ST_RESP) && (owner_q == PORT_C);
    assign d_rsp_valid = (state_q == ST_RESP) && (owner_q == PORT_D);
    assign c_rsp_rdata = (owner_q == PORT_C) ? rdata_q : '0;
    assign d_rsp_rdata = (owner_q == PORT_D) ? rdata_q : '0;
    assign c_rsp_err   = c_rsp_valid && err_q;
    assign d_rsp_err   = d_rsp_valid && err_q;

endmodule
